// File: rtl/dff_bist_ctrl.sv
// Self-test sequencer for one resettable D flip-flop: checks Q clears under reset, then
// compares Q against an LFSR stream delayed by LAT. Optional DFF_BIST_QN_EN adds DUT_QN checks.
module dff_bist_ctrl #(
  parameter int         RST_CYCLES = 4,
  parameter int         LAT        = 1,
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [CNT_W-1:0] RUN_LEN,
  output logic             DUT_RESET_B,
  output logic             DUT_D,
  input  logic             DUT_Q,
`ifdef DFF_BIST_QN_EN
  input  logic             DUT_QN,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int         RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [RST_W-1:0] rst_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [3:0]       drain_cnt;
  logic [7:0]       lfsr;
  logic [LAT:0]     pipe_vld;
  logic [LAT:0]     pipe_bit;

  logic             start_ok;
  logic             rst_chk;
  logic [1:0]       inc;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_next;
  logic             push_vld;

  // START is only honoured once DONE is visible, so the final compare never races a restart.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    start_ok = START && ((state == S_IDLE) || ((state == S_DONE) && DONE));
    rst_chk  = (state == S_RST) && (rst_cnt == '0);
    push_vld = (state == S_RUN);
    inc      = 2'd0;
    if (rst_chk && DUT_Q) inc = inc + 2'd1;
    if (pipe_vld[LAT] && (DUT_Q != pipe_bit[LAT])) inc = inc + 2'd1;
`ifdef DFF_BIST_QN_EN
    if (rst_chk && !DUT_QN) inc = inc + 2'd1;
    if (pipe_vld[LAT] && (DUT_QN == DUT_Q)) inc = inc + 2'd1;
`endif
    err_sum  = {1'b0, ERR_CNT} + (CNT_W+1)'(inc);
    err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  // Outputs are registered from the current state, so they trail the state register by one cycle;
  // pipe[0] therefore lines up with DUT_D and pipe[LAT] with DUT_Q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: all state uses non-blocking assignments; the expected pipe is reset like any register.
      state       <= S_IDLE;
      rst_cnt     <= '0;
      run_cnt     <= '0;
      drain_cnt   <= '0;
      lfsr        <= SEED_EFF;
      pipe_vld    <= '0;
      pipe_bit    <= '0;
      DUT_RESET_B <= 1'b0;
      DUT_D       <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      PASS        <= 1'b0;
      ERR_CNT     <= '0;
    end else begin
      BUSY        <= (state == S_RST) || (state == S_RUN) || (state == S_DRAIN);
      DONE        <= (state == S_DONE) && !start_ok;
      PASS        <= (state == S_DONE) && !start_ok && (err_next == '0);
      DUT_RESET_B <= (state == S_RUN) || (state == S_DRAIN);
      ERR_CNT     <= start_ok ? '0 : err_next;
      pipe_vld    <= {pipe_vld[LAT-1:0], push_vld};
      pipe_bit    <= {pipe_bit[LAT-1:0], push_vld & lfsr[0]};

      case (state)
        S_RUN:   DUT_D <= lfsr[0];
        S_DRAIN: DUT_D <= DUT_D;
        default: DUT_D <= 1'b0;
      endcase

      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            run_cnt <= RUN_LEN;
            lfsr    <= SEED_EFF;
            rst_cnt <= RST_W'(RST_CYCLES - 1);
            state   <= S_RST;
          end
        end
        S_RST: begin
          if (rst_cnt == '0) begin
            drain_cnt <= 4'(LAT - 1);
            state     <= (run_cnt != '0) ? S_RUN : S_DRAIN;
          end else begin
            rst_cnt <= rst_cnt - RST_W'(1);
          end
        end
        S_RUN: begin
          // x^8+x^6+x^5+x^4+1, shifting toward bit 0
          lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
          run_cnt <= run_cnt - CNT_W'(1);
          if (run_cnt == CNT_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt == 4'd0) state <= S_DONE;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bist_ctrl.sv
// Bench for dff_bist_ctrl: table of runs against behavioural flop models plus abort,
// ignored-START and saturation sequences. Builds with or without DFF_BIST_QN_EN.
module tb_dff_bist_ctrl;

`ifdef DFF_BIST_QN_EN
  localparam int QN_X = 1;
`else
  localparam int QN_X = 0;
`endif

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, START, START_B;
  logic [15:0] RUN_LEN;
  logic [3:0]  RUN_LEN_B;

  logic        rb_a, d_a, q_a, busy_a, done_a, pass_a, ff_a;
  logic [15:0] err_a;
  logic        rb_b, d_b, q_b, busy_b, done_b, pass_b, ff_b;
  logic [3:0]  err_b;
  logic [1:0]  mode_a;  // 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 inverted Q

  // Behavioural dfrbpq models: async active-low reset, one cycle latency.
  always_ff @(posedge CLK or negedge rb_a)
    if (!rb_a) ff_a <= 1'b0;
    else       ff_a <= d_a;

  always_ff @(posedge CLK or negedge rb_b)
    if (!rb_b) ff_b <= 1'b0;
    else       ff_b <= d_b;

  always_comb begin
    case (mode_a)
      2'd1:    q_a = 1'b1;
      2'd2:    q_a = 1'b0;
      2'd3:    q_a = ~ff_a;
      default: q_a = ff_a;
    endcase
  end
  assign q_b = ~ff_b;

`ifdef DFF_BIST_QN_EN
  logic qn_tie, qn_a, qn_b;
  assign qn_a = qn_tie ? q_a : ~q_a;
  assign qn_b = ~q_b;
`endif

  dff_bist_ctrl u_dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RUN_LEN(RUN_LEN),
    .DUT_RESET_B(rb_a), .DUT_D(d_a), .DUT_Q(q_a),
`ifdef DFF_BIST_QN_EN
    .DUT_QN(qn_a),
`endif
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a)
  );

  dff_bist_ctrl #(.CNT_W(4)) u_sat (
    .CLK(CLK), .RESET(RESET), .START(START_B), .RUN_LEN(RUN_LEN_B),
    .DUT_RESET_B(rb_b), .DUT_D(d_b), .DUT_Q(q_b),
`ifdef DFF_BIST_QN_EN
    .DUT_QN(qn_b),
`endif
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Pulse START, then watch until DONE (bounded); collects BUSY/RESET_B counts and DUT_D bits.
  task automatic run_a(input int len, input logic [1:0] mode, output int lat,
                       output int busy_n, output int rb_n, output logic [15:0] dbits);
    logic [15:0] bits;
    mode_a = mode;
    @(negedge CLK);
    START   = 1'b1;
    RUN_LEN = 16'(len);
    @(negedge CLK);
    START  = 1'b0;
    lat    = -1;
    busy_n = 0;
    rb_n   = 0;
    bits   = '0;
    for (int m = 1; m <= 200 && lat < 0; m++) begin
      @(negedge CLK);
      if (busy_a) busy_n++;
      if (rb_a) begin
        if (rb_n < 16 && rb_n < len) bits[rb_n] = d_a;
        rb_n++;
      end
      if (done_a) lat = m;
    end
    dbits = bits;
  endtask

  task automatic wait_done_b(output int lat);
    lat = -1;
    for (int m = 1; m <= 200 && lat < 0; m++) begin
      @(negedge CLK);
      if (done_b) lat = m;
    end
  endtask

  typedef struct {
    int         len;
    logic [1:0] mode;
    int         exp_err;
    logic       exp_pass;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] exp_seq;
    logic [15:0] dbits, mask;
    int          lat, busy_n, rb_n, seen;

    // First 16 bits out of the LFSR from 8'hA5, bit i = i-th DUT_D value.
    exp_seq   = 16'h72A5;
    RESET     = 1'b1;
    START     = 1'b0;
    START_B   = 1'b0;
    RUN_LEN   = '0;
    RUN_LEN_B = '0;
    mode_a    = 2'd0;
`ifdef DFF_BIST_QN_EN
    qn_tie = 1'b0;
`endif

    repeat (2) @(negedge CLK);
    check("rst_reset_b", rb_a, 0);
    check("rst_d", d_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_err_b", err_b, 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_busy", busy_a, 0);
    check("idle_done", done_a, 0);

    //               len  mode  err        pass  DONE edge
    vecs[0] = '{16, 2'd0, 0,             1'b1, 22};
    vecs[1] = '{ 8, 2'd1, 5 + QN_X,      1'b0, 14};
    vecs[2] = '{ 0, 2'd0, 0,             1'b1,  6};
    vecs[3] = '{ 3, 2'd1, 2 + QN_X,      1'b0,  9};
    vecs[4] = '{ 5, 2'd2, 2,             1'b0, 11};
    vecs[5] = '{16, 2'd3, 17 + QN_X,     1'b0, 22};

    for (int v = 0; v < 6; v++) begin
      run_a(vecs[v].len, vecs[v].mode, lat, busy_n, rb_n, dbits);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_err", v), err_a, vecs[v].exp_err);
      check($sformatf("v%0d_pass", v), pass_a, vecs[v].exp_pass);
      check($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_lat - 1);
      check($sformatf("v%0d_resetb_high", v), rb_n, vecs[v].len + 1);
      if (vecs[v].len > 0) begin
        mask = '0;
        for (int i = 0; i < vecs[v].len && i < 16; i++) mask[i] = 1'b1;
        check($sformatf("v%0d_dseq", v), dbits & mask, exp_seq & mask);
      end
      @(negedge CLK);
      check($sformatf("v%0d_done_hold", v), done_a, 1);
    end

    // START pulsed mid-RUN must be ignored.
    mode_a = 2'd0;
    @(negedge CLK);
    START   = 1'b1;
    RUN_LEN = 16'd8;
    @(negedge CLK);
    START = 1'b0;
    lat   = -1;
    rb_n  = 0;
    dbits = '0;
    for (int m = 1; m <= 200 && lat < 0; m++) begin
      @(negedge CLK);
      if (m == 6) begin
        START   = 1'b1;
        RUN_LEN = 16'd2;
      end
      if (m == 7) START = 1'b0;
      if (rb_a) begin
        if (rb_n < 8) dbits[rb_n] = d_a;
        rb_n++;
      end
      if (done_a) lat = m;
    end
    check("ign_start_latency", lat, 14);
    check("ign_start_err", err_a, 0);
    check("ign_start_dseq", dbits[7:0], 8'hA5);

    // RESET on the third RUN cycle aborts without DONE.
    mode_a = 2'd1;
    @(negedge CLK);
    START   = 1'b1;
    RUN_LEN = 16'd16;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    check("abort_pre_err", err_a, 1 + QN_X);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_reset_b", rb_a, 0);
    check("abort_d", d_a, 0);
    check("abort_err", err_a, 0);
    check("abort_done", done_a, 0);
    check("abort_busy", busy_a, 0);
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (done_a || busy_a) seen++;
    end
    check("abort_stays_idle", seen, 0);

    // 4-bit counter saturates, then a new START clears it.
    @(negedge CLK);
    START_B   = 1'b1;
    RUN_LEN_B = 4'd15;
    @(negedge CLK);
    START_B = 1'b0;
    wait_done_b(lat);
    check("sat_latency", lat, 21);
    check("sat_err", err_b, 15);
    check("sat_pass", pass_b, 0);
    @(negedge CLK);
    START_B   = 1'b1;
    RUN_LEN_B = 4'd0;
    @(negedge CLK);
    START_B = 1'b0;
    check("sat_cleared", err_b, 0);
    wait_done_b(lat);
    check("sat2_latency", lat, 6);
    check("sat2_err", err_b, 1 + QN_X);

`ifdef DFF_BIST_QN_EN
    // Q_N tied to Q: last RST cycle fails Q_N==1, every stream cycle fails Q_N==~Q.
    qn_tie = 1'b1;
    run_a(4, 2'd0, lat, busy_n, rb_n, dbits);
    check("qn_tie_latency", lat, 10);
    check("qn_tie_err", err_a, 5);
    check("qn_tie_pass", pass_a, 0);
    qn_tie = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "watchdog expired");
  end

endmodule
